// File: rtl/proc_pkg.sv
// Shared definitions for the fetch front end and Control_Unit: default
// widths, the HALT opcode and the fetch FSM state encoding.
package proc_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int INSTR_W_DEF = 8;

  localparam logic [7:0] OPC_HALT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO holding {pc, instr} pairs. Entry 0 is always the head so
// the consumer sees a registered output. Popping the last entry leaves the
// head register untouched, so the presented word holds its last value.
module fetch_fifo2
  import proc_pkg::*;
#(
  parameter int W = ADDR_W_DEF + INSTR_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   count_q, count_d;

  // Entry and occupancy registers; reset clears the head so outputs start at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  // Next-state: flush empties, otherwise shift/append depending on push/pop.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      unique case ({push_i, pop_i})
        2'b11: begin
          if (count_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = push_data_i;
          end else begin
            e0_d = push_data_i;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) e0_d = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) e0_d = push_data_i;
          else                 e1_d = push_data_i;
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head_o  = e0_q;
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Streamed instruction fetch: PC, 16-word ROM with registered read, and a
// 2-entry prefetch buffer feeding Control_Unit over valid/ready. Reads are
// issued only while the buffer plus the in-flight read leave room, so the
// buffer can never overflow. start/branch/HALT flush the buffer and squash
// the in-flight read.
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int    ADDR_W   = ADDR_W_DEF,
  parameter int    INSTR_W  = INSTR_W_DEF,
  parameter string ROM_FILE = "program.mem"
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_idx,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               busy,
  output logic               halted
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Built-in program image: word k = 0x10+k, with HALT at address 6.
  function automatic logic [INSTR_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [INSTR_W-1:0] w;
    if (a == ADDR_W'(6)) w = INSTR_W'(OPC_HALT);
    else                 w = INSTR_W'(8'h10) + INSTR_W'(a);
    return w;
  endfunction

  logic [INSTR_W-1:0] rom [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = rom_word(ADDR_W'(g));
  end

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                inflight_q;
  logic [INSTR_W-1:0]  rom_data_q;
  logic [ADDR_W-1:0]   rd_pc_q;

  logic                flush, issue, push, pop, halt_pop;
  logic [1:0]          count;
  logic [2:0]          occ;
  logic [ADDR_W+INSTR_W-1:0] head;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid & instr_ready;
  assign halt_pop    = pop & (instr == {INSTR_W{1'b1}});
  assign occ         = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  // Data returning this cycle is dropped when a flush happens now.
  assign push        = inflight_q & ~flush;

  // FSM, PC and in-flight flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= issue;
    end
  end

  // Registered ROM read; qualified by the in-flight flag so no reset needed.
  always_ff @(posedge clk) begin
    if (issue) begin
      rom_data_q <= rom[pc_q];
      rd_pc_q    <= pc_q;
    end
  end

  // Next-state and issue decision; start beats branch beats HALT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = start_idx;
          flush   = 1'b1;
        end
      end
      ST_FETCH: begin
        if (start) begin
          pc_d  = start_idx;
          flush = 1'b1;
        end else if (branch_en) begin
          pc_d  = branch_addr;
          flush = 1'b1;
        end else if (halt_pop) begin
          state_d = ST_HALTED;
          flush   = 1'b1;
        end else if (occ < 3'd2) begin
          issue = 1'b1;
          pc_d  = pc_q + ADDR_W'(1);
        end
      end
      ST_HALTED: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = start_idx;
          flush   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fetch_fifo2 #(.W(ADDR_W + INSTR_W)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i ({rd_pc_q, rom_data_q}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign instr_pc = head[ADDR_W+INSTR_W-1:INSTR_W];
  assign instr    = head[INSTR_W-1:0];
  assign busy     = (state_q == ST_FETCH);
  assign halted   = (state_q == ST_HALTED);

endmodule
